axi_slave_decerr: RTL and testbench
===================================

# axi_slave_decerr

Terminating AXI4 slave for the unmapped address hole of the AXI interconnect: it sits on the slave port the interconnect routes to when no address window matches. It accepts every write and read burst, consumes all write data, returns one write response per write burst and LEN+1 read beats per read burst, all with a fixed error response code. Masters that hit an unmapped address therefore complete instead of hanging. Independent read and write channels, saturating error counters for debug.

## Interface
Parameters:
- ID_WIDTH, 4, width of AXI ID fields
- ADDR_WIDTH, 32, address width (address captured for debug only)
- DATA_WIDTH, 32, data width
- RESP_CODE, 2'b11, response driven on WR_BACK_RESP and RD_DATA_RESP (DECERR)
- RD_FILL, 0, constant value on RD_DATA during read beats

Ports:
- clk  in  1  single clock; everything synchronous to rising edge
- rstn  in  1  synchronous, active-low reset
- WR_ADDR_ID / WR_ADDR / WR_ADDR_LEN / WR_ADDR_VALID  in  ID_WIDTH / ADDR_WIDTH / 8 / 1  write address channel
- WR_ADDR_READY  out  1  write address accept
- WR_DATA / WR_STRB / WR_DATA_LAST / WR_DATA_VALID  in  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  write data channel (data, strobe ignored)
- WR_DATA_READY  out  1  write data accept
- WR_BACK_ID / WR_BACK_RESP / WR_BACK_VALID  out  ID_WIDTH / 2 / 1  write response channel
- WR_BACK_READY  in  1  write response accept
- RD_ADDR_ID / RD_ADDR / RD_ADDR_LEN / RD_ADDR_VALID  in  ID_WIDTH / ADDR_WIDTH / 8 / 1  read address channel
- RD_ADDR_READY  out  1  read address accept
- RD_BACK_ID / RD_DATA / RD_DATA_RESP / RD_DATA_LAST / RD_DATA_VALID  out  ID_WIDTH / DATA_WIDTH / 2 / 1 / 1  read data channel
- RD_DATA_READY  in  1  read data accept
- WR_ERR_CNT  out  16  completed write bursts, saturating at 16'hFFFF
- RD_ERR_CNT  out  16  completed read bursts, saturating at 16'hFFFF

## Operation
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: WR_ADDR_READY=1. On WR_ADDR_VALID&&READY latch WR_ADDR_ID, WR_ADDR; go W_DATA.
  - W_DATA: WR_DATA_READY=1. Every handshaken beat is discarded. Beat with WR_DATA_LAST=1 -> W_RESP. Burst termination is by WR_DATA_LAST only; WR_ADDR_LEN is not checked.
  - W_RESP: WR_BACK_VALID=1, WR_BACK_ID=latched ID, WR_BACK_RESP=RESP_CODE, held stable until WR_BACK_READY; on handshake increment WR_ERR_CNT (saturating), go W_IDLE.
  - Write data presented before its address is not accepted (WR_DATA_READY=0 outside W_DATA).
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: RD_ADDR_READY=1. On handshake latch ID, LEN; beat counter=0; go R_DATA.
  - R_DATA: RD_DATA_VALID=1, RD_DATA=RD_FILL, RD_DATA_RESP=RESP_CODE, RD_BACK_ID=latched ID, RD_DATA_LAST=(counter==LEN). Counter increments on each RD_DATA_VALID&&READY. Handshake of last beat: increment RD_ERR_CNT (saturating), go R_IDLE.
  - Outputs held stable while VALID=1 and READY=0.
- Read and write FSMs fully independent; simultaneous AW and AR both accepted in the same cycle.
- One outstanding transaction per direction; no interleaving, no reordering.

## Timing
- Reset (rstn=0 at clock edge): both FSMs to IDLE, counters to 0. Reset values: WR_ADDR_READY=1, RD_ADDR_READY=1 (first cycle after reset release; driven 0 while rstn=0), all other outputs 0. Reset mid-burst abandons the burst with no response.
- All outputs registered or decoded from state registers only; no combinational path from any input to any output.
- Write, single beat, READY always high: AW handshake cycle 0, W beat cycle 1, WR_BACK_VALID cycle 2, handshake cycle 2, WR_ADDR_READY=1 again cycle 3.
- Read, LEN=L, READY always high: AR handshake cycle 0, beats cycles 1..L+1, RD_DATA_LAST on cycle L+1, RD_ADDR_READY=1 cycle L+2.
- LEN=255: counter 8 bits, LAST on beat 256, no wrap before LAST.
- Counter saturation: at 16'hFFFF further completions leave it unchanged.

## Test plan
- Single write ID=3, LEN=0, all READY high -> WR_BACK_VALID on cycle 2, WR_BACK_ID=3, WR_BACK_RESP=2'b11, WR_ERR_CNT=1.
- Read ID=5, LEN=3, RD_DATA_READY toggling 1/0 -> exactly 4 beats, RD_DATA=0, RESP=2'b11, LAST only on 4th, outputs stable during stalls, RD_ERR_CNT=1.
- Write data VALID before address, LEN=7 with WR_BACK_READY held low 10 cycles -> no data accepted before AW; 8 beats consumed; WR_BACK_VALID held 10 cycles then handshake; next AW accepted following cycle.
- Simultaneous AW (ID=1) and AR (ID=2, LEN=255) in same cycle -> both accepted cycle 0; B with ID=1 and 256 R beats with ID=2, LAST on beat 256.
- rstn low for 1 cycle during read beat 2 of LEN=7 -> all outputs 0 during reset, both READYs 1 after, no further R beats, counters 0.
- 65537 back-to-back single-beat writes -> WR_ERR_CNT stops at 16'hFFFF.

Source files
------------

// File: rtl/axi_slave_decerr.sv
// axi_slave_decerr: AXI4 slave that terminates every burst with a fixed error response.
// Ports: clk/rstn (sync, active-low); write address/data/response channels (WR_ADDR_*, WR_DATA*,
// WR_STRB, WR_BACK_*); read address/data channels (RD_ADDR_*, RD_BACK_ID, RD_DATA*);
// WR_ERR_CNT/RD_ERR_CNT count completed bursts and saturate at 16'hFFFF.
module axi_slave_decerr #(
  parameter int ID_WIDTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [1:0] RESP_CODE = 2'b11,
  parameter logic [DATA_WIDTH-1:0] RD_FILL = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ID_WIDTH-1:0]     WR_ADDR_ID,
  input  logic [ADDR_WIDTH-1:0]   WR_ADDR,
  input  logic [7:0]              WR_ADDR_LEN,
  input  logic                    WR_ADDR_VALID,
  output logic                    WR_ADDR_READY,
  input  logic [DATA_WIDTH-1:0]   WR_DATA,
  input  logic [DATA_WIDTH/8-1:0] WR_STRB,
  input  logic                    WR_DATA_LAST,
  input  logic                    WR_DATA_VALID,
  output logic                    WR_DATA_READY,
  output logic [ID_WIDTH-1:0]     WR_BACK_ID,
  output logic [1:0]              WR_BACK_RESP,
  output logic                    WR_BACK_VALID,
  input  logic                    WR_BACK_READY,
  input  logic [ID_WIDTH-1:0]     RD_ADDR_ID,
  input  logic [ADDR_WIDTH-1:0]   RD_ADDR,
  input  logic [7:0]              RD_ADDR_LEN,
  input  logic                    RD_ADDR_VALID,
  output logic                    RD_ADDR_READY,
  output logic [ID_WIDTH-1:0]     RD_BACK_ID,
  output logic [DATA_WIDTH-1:0]   RD_DATA,
  output logic [1:0]              RD_DATA_RESP,
  output logic                    RD_DATA_LAST,
  output logic                    RD_DATA_VALID,
  input  logic                    RD_DATA_READY,
  output logic [15:0]             WR_ERR_CNT,
  output logic [15:0]             RD_ERR_CNT
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic [7:0] rd_len, rd_cnt;
  // Addresses are kept for debug visibility only; payload, strobes and write length are ignored.
  logic unused;
  assign unused = ^{WR_ADDR_LEN, WR_DATA, WR_STRB, wr_addr_q, rd_addr_q};
  // Address READY comes up one edge after reset release so it reads 0 for the whole reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      WR_ADDR_READY <= 1'b0;
      WR_DATA_READY <= 1'b0;
      WR_BACK_VALID <= 1'b0;
      WR_BACK_ID <= '0;
      WR_BACK_RESP <= '0;
      wr_addr_q <= '0;
      WR_ERR_CNT <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          WR_ADDR_READY <= 1'b1;
          if (WR_ADDR_VALID && WR_ADDR_READY) begin
            WR_ADDR_READY <= 1'b0;
            WR_DATA_READY <= 1'b1;
            WR_BACK_ID <= WR_ADDR_ID;
            wr_addr_q <= WR_ADDR;
            w_state <= W_DATA;
          end
        end
        W_DATA: if (WR_DATA_VALID && WR_DATA_READY && WR_DATA_LAST) begin
          WR_DATA_READY <= 1'b0;
          WR_BACK_VALID <= 1'b1;
          WR_BACK_RESP <= RESP_CODE;
          w_state <= W_RESP;
        end
        W_RESP: if (WR_BACK_READY) begin
          WR_BACK_VALID <= 1'b0;
          WR_ADDR_READY <= 1'b1;
          WR_ERR_CNT <= WR_ERR_CNT + {15'd0, WR_ERR_CNT != 16'hFFFF};
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
  // LAST is precomputed from the next beat index so it stays a pure register output.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= R_IDLE;
      RD_ADDR_READY <= 1'b0;
      RD_BACK_ID <= '0;
      RD_DATA <= '0;
      RD_DATA_RESP <= '0;
      RD_DATA_LAST <= 1'b0;
      RD_DATA_VALID <= 1'b0;
      rd_len <= '0;
      rd_cnt <= '0;
      rd_addr_q <= '0;
      RD_ERR_CNT <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          RD_ADDR_READY <= 1'b1;
          if (RD_ADDR_VALID && RD_ADDR_READY) begin
            RD_ADDR_READY <= 1'b0;
            RD_BACK_ID <= RD_ADDR_ID;
            RD_DATA <= RD_FILL;
            RD_DATA_RESP <= RESP_CODE;
            RD_DATA_LAST <= RD_ADDR_LEN == 8'd0;
            RD_DATA_VALID <= 1'b1;
            rd_len <= RD_ADDR_LEN;
            rd_cnt <= '0;
            rd_addr_q <= RD_ADDR;
            r_state <= R_DATA;
          end
        end
        R_DATA: if (RD_DATA_READY) begin
          if (RD_DATA_LAST) begin
            RD_DATA_VALID <= 1'b0;
            RD_DATA_LAST <= 1'b0;
            RD_ADDR_READY <= 1'b1;
            RD_ERR_CNT <= RD_ERR_CNT + {15'd0, RD_ERR_CNT != 16'hFFFF};
            r_state <= R_IDLE;
          end else begin
            rd_cnt <= rd_cnt + 8'd1;
            RD_DATA_LAST <= (rd_cnt + 8'd1) == rd_len;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_slave_decerr.sv
// tb_axi_slave_decerr: table-driven and scoreboard bench for axi_slave_decerr.
module tb_axi_slave_decerr;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] WR_ADDR_ID = '0, RD_ADDR_ID = '0, WR_BACK_ID, RD_BACK_ID;
  logic [31:0] WR_ADDR = '0, RD_ADDR = '0, WR_DATA = '0, RD_DATA;
  logic [7:0] WR_ADDR_LEN = '0, RD_ADDR_LEN = '0;
  logic [3:0] WR_STRB = 4'hF;
  logic WR_ADDR_VALID = 0, WR_DATA_LAST = 0, WR_DATA_VALID = 0, WR_BACK_READY = 1;
  logic RD_ADDR_VALID = 0, RD_DATA_READY = 1;
  logic WR_ADDR_READY, WR_DATA_READY, WR_BACK_VALID, RD_ADDR_READY, RD_DATA_LAST, RD_DATA_VALID;
  logic [1:0] WR_BACK_RESP, RD_DATA_RESP;
  logic [15:0] WR_ERR_CNT, RD_ERR_CNT;

  axi_slave_decerr dut (
    .clk(clk), .rstn(rstn),
    .WR_ADDR_ID(WR_ADDR_ID), .WR_ADDR(WR_ADDR), .WR_ADDR_LEN(WR_ADDR_LEN),
    .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
    .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_DATA_LAST(WR_DATA_LAST),
    .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_READY(WR_DATA_READY),
    .WR_BACK_ID(WR_BACK_ID), .WR_BACK_RESP(WR_BACK_RESP), .WR_BACK_VALID(WR_BACK_VALID),
    .WR_BACK_READY(WR_BACK_READY),
    .RD_ADDR_ID(RD_ADDR_ID), .RD_ADDR(RD_ADDR), .RD_ADDR_LEN(RD_ADDR_LEN),
    .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
    .RD_BACK_ID(RD_BACK_ID), .RD_DATA(RD_DATA), .RD_DATA_RESP(RD_DATA_RESP),
    .RD_DATA_LAST(RD_DATA_LAST), .RD_DATA_VALID(RD_DATA_VALID), .RD_DATA_READY(RD_DATA_READY),
    .WR_ERR_CNT(WR_ERR_CNT), .RD_ERR_CNT(RD_ERR_CNT)
  );

  typedef struct {logic [3:0] id; logic last;} r_exp_t;
  typedef struct {bit is_rd; logic [3:0] id; logic [7:0] len; int stall; bit toggle; logic [15:0] ew; logic [15:0] er;} vec_t;
  r_exp_t r_q[$];
  logic [3:0] b_q[$];
  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: event did not occur as expected", nm);
  endtask

  function automatic logic [79:0] rest();
    return {WR_DATA_READY, WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID, RD_BACK_ID, RD_DATA,
            RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID, WR_ERR_CNT, RD_ERR_CNT};
  endfunction

  function automatic logic sig(input int k);
    return k == 0 ? WR_ADDR_READY : k == 1 ? WR_DATA_READY : k == 2 ? WR_BACK_VALID : RD_ADDR_READY;
  endfunction

  // Waits for the selected READY/VALID at a negedge, then steps past the handshake edge.
  task automatic wait_for(input int k, input string nm);
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (sig(k)) begin
        @(posedge clk); #1;
        return;
      end
    end
    fail({"timeout ", nm});
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit toggle, input int limit, input string nm);
    for (int t = 0; t < limit; t++) begin
      if (r_q.size() == 0 && b_q.size() == 0) return;
      @(posedge clk); #1;
      if (toggle) RD_DATA_READY = !RD_DATA_READY;
    end
    fail({"timeout ", nm});
    r_q.delete();
    b_q.delete();
  endtask

  task automatic do_write(input logic [3:0] id, input logic [7:0] len, input int stall);
    b_q.push_back(id);
    WR_BACK_READY = (stall == 0);
    WR_ADDR_ID = id; WR_ADDR = $urandom; WR_ADDR_LEN = len; WR_ADDR_VALID = 1;
    wait_for(0, "aw");
    WR_ADDR_VALID = 0;
    for (int i = 0; i <= int'(len); i++) begin
      WR_DATA_VALID = 1; WR_DATA_LAST = (i == int'(len)); WR_DATA = $urandom;
      wait_for(1, "w");
    end
    WR_DATA_VALID = 0; WR_DATA_LAST = 0;
    if (stall > 0) begin
      wait_for(2, "b_valid");
      for (int s = 1; s < stall; s++) begin
        @(negedge clk); chk("b_hold", WR_BACK_VALID, 1'b1);
        @(posedge clk); #1;
      end
      WR_BACK_READY = 1;
    end
    wait_for(2, "b");
  endtask

  task automatic do_read(input logic [3:0] id, input logic [7:0] len, input bit toggle);
    for (int i = 0; i <= int'(len); i++) r_q.push_back('{id, i == int'(len)});
    RD_DATA_READY = 1;
    RD_ADDR_ID = id; RD_ADDR = $urandom; RD_ADDR_LEN = len; RD_ADDR_VALID = 1;
    wait_for(3, "ar");
    RD_ADDR_VALID = 0;
    drain(toggle, 1200, "r_beats");
    RD_DATA_READY = 1;
  endtask

  // Scoreboard side: pops expectations on every handshake and checks stability during stalls.
  r_exp_t re;
  logic [3:0] bid;
  logic [39:0] prv_r;
  logic [6:0] prv_b;
  bit stall_r = 0, stall_b = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      stall_r = 0; stall_b = 0;
    end else begin
      if (stall_r) chk("r_stable", {RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID}, prv_r);
      if (stall_b) chk("b_stable", {WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID}, prv_b);
      if (RD_DATA_VALID && RD_DATA_READY) begin
        if (r_q.size() == 0) fail("r_unexpected_beat");
        else begin
          re = r_q.pop_front();
          chk("r_id", RD_BACK_ID, re.id);
          chk("r_last", RD_DATA_LAST, re.last);
          chk("r_data", RD_DATA, 32'd0);
          chk("r_resp", RD_DATA_RESP, 2'b11);
        end
      end
      if (WR_BACK_VALID && WR_BACK_READY) begin
        if (b_q.size() == 0) fail("b_unexpected");
        else begin
          bid = b_q.pop_front();
          chk("b_id", WR_BACK_ID, bid);
          chk("b_resp", WR_BACK_RESP, 2'b11);
        end
      end
      stall_r = RD_DATA_VALID && !RD_DATA_READY;
      prv_r = {RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID};
      stall_b = WR_BACK_VALID && !WR_BACK_READY;
      prv_b = {WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t tbl[6];
  initial begin
    tbl = '{
      '{1'b1, 4'd5,  8'd3,  0, 1'b1, 16'd1, 16'd1},
      '{1'b0, 4'd9,  8'd2,  3, 1'b0, 16'd2, 16'd1},
      '{1'b1, 4'd0,  8'd0,  0, 1'b0, 16'd2, 16'd2},
      '{1'b1, 4'd15, 8'd15, 0, 1'b1, 16'd2, 16'd3},
      '{1'b0, 4'd6,  8'd15, 0, 1'b0, 16'd3, 16'd3},
      '{1'b0, 4'd12, 8'd0,  1, 1'b0, 16'd4, 16'd3}
    };
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", {WR_ADDR_READY, RD_ADDR_READY}, 2'b00);
    chk("rst_outputs", rest(), 80'd0);
    @(posedge clk); #1; rstn = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_rst", {WR_ADDR_READY, RD_ADDR_READY}, 2'b11);
    chk("outputs_after_rst", rest(), 80'd0);
    @(posedge clk); #1;

    // Single write ID=3: AW cycle 0, W cycle 1, B cycle 2, AW ready cycle 3
    b_q.push_back(4'd3);
    WR_ADDR_ID = 3; WR_ADDR_LEN = 0; WR_ADDR = 32'h1000; WR_ADDR_VALID = 1;
    @(negedge clk); chk("c0_aw_ready", WR_ADDR_READY, 1'b1);
    @(posedge clk); #1; WR_ADDR_VALID = 0; WR_DATA_VALID = 1; WR_DATA_LAST = 1;
    @(negedge clk); chk("c1_w_ready", {WR_DATA_READY, WR_BACK_VALID, WR_ADDR_READY}, 3'b100);
    @(posedge clk); #1; WR_DATA_VALID = 0; WR_DATA_LAST = 0;
    @(negedge clk); chk("c2_b_valid", {WR_BACK_VALID, WR_DATA_READY}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("c3_aw_ready", {WR_ADDR_READY, WR_BACK_VALID}, 2'b10);
    chk("c3_wr_cnt", WR_ERR_CNT, 16'd1);
    @(posedge clk); #1;

    // Table of bursts; per-beat results come from the scoreboard
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].is_rd) do_read(tbl[i].id, tbl[i].len, tbl[i].toggle);
      else do_write(tbl[i].id, tbl[i].len, tbl[i].stall);
      @(negedge clk);
      chk($sformatf("v%0d_wr_cnt", i), WR_ERR_CNT, tbl[i].ew);
      chk($sformatf("v%0d_rd_cnt", i), RD_ERR_CNT, tbl[i].er);
      @(posedge clk); #1;
    end

    // Write data presented before its address, LEN=7, B stalled 10 cycles
    WR_DATA_VALID = 1; WR_DATA_LAST = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("early_w_blocked", WR_DATA_READY, 1'b0);
      @(posedge clk); #1;
    end
    WR_BACK_READY = 0;
    b_q.push_back(4'd7);
    WR_ADDR_ID = 7; WR_ADDR_LEN = 7; WR_ADDR_VALID = 1;
    wait_for(0, "early_aw");
    WR_ADDR_VALID = 0;
    for (int i = 0; i < 8; i++) begin
      WR_DATA_LAST = (i == 7); WR_DATA = $urandom;
      wait_for(1, "early_w");
    end
    WR_DATA_VALID = 0; WR_DATA_LAST = 0;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      chk("early_b_hold", {WR_BACK_VALID, WR_DATA_READY}, 2'b10);
      @(posedge clk); #1;
    end
    WR_BACK_READY = 1;
    @(negedge clk);
    @(posedge clk); #1;
    b_q.push_back(4'd8);
    WR_ADDR_ID = 8; WR_ADDR_LEN = 0; WR_ADDR_VALID = 1;
    @(negedge clk); chk("aw_after_b", WR_ADDR_READY, 1'b1);
    @(posedge clk); #1; WR_ADDR_VALID = 0;
    @(negedge clk); chk("aw_after_b_taken", WR_DATA_READY, 1'b1);
    @(posedge clk); #1; WR_DATA_VALID = 1; WR_DATA_LAST = 1;
    wait_for(1, "w_after_b");
    WR_DATA_VALID = 0; WR_DATA_LAST = 0;
    wait_for(2, "b_after_b");
    @(negedge clk); chk("early_wr_cnt", WR_ERR_CNT, 16'd6);
    @(posedge clk); #1;

    // Simultaneous AW (ID=1) and AR (ID=2, LEN=255)
    b_q.push_back(4'd1);
    for (int i = 0; i < 256; i++) r_q.push_back('{4'd2, i == 255});
    WR_ADDR_ID = 1; WR_ADDR_LEN = 0; WR_ADDR_VALID = 1;
    RD_ADDR_ID = 2; RD_ADDR_LEN = 8'd255; RD_ADDR_VALID = 1;
    @(negedge clk); chk("aw_ar_same_cycle", {WR_ADDR_READY, RD_ADDR_READY}, 2'b11);
    @(posedge clk); #1;
    WR_ADDR_VALID = 0; RD_ADDR_VALID = 0; WR_DATA_VALID = 1; WR_DATA_LAST = 1;
    wait_for(1, "sim_w");
    WR_DATA_VALID = 0; WR_DATA_LAST = 0;
    drain(1'b0, 400, "sim_drain");
    @(negedge clk);
    chk("sim_cnts", {WR_ERR_CNT, RD_ERR_CNT}, {16'd7, 16'd4});
    chk("sim_ready", {WR_ADDR_READY, RD_ADDR_READY}, 2'b11);
    @(posedge clk); #1;

    // Reset for one cycle during beat 2 of a LEN=7 read
    for (int i = 0; i < 8; i++) r_q.push_back('{4'd4, i == 7});
    RD_ADDR_ID = 4; RD_ADDR_LEN = 7; RD_ADDR_VALID = 1;
    wait_for(3, "rst_ar");
    RD_ADDR_VALID = 0;
    @(posedge clk); #1; rstn = 0;
    @(posedge clk); #1; rstn = 1; r_q.delete();
    @(negedge clk);
    chk("midrst_ready", {WR_ADDR_READY, RD_ADDR_READY}, 2'b00);
    chk("midrst_outputs", rest(), 80'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst_ready", {WR_ADDR_READY, RD_ADDR_READY}, 2'b11);
    chk("postrst_outputs", rest(), 80'd0);
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk); chk("postrst_no_beats", {RD_DATA_VALID, RD_ERR_CNT, WR_ERR_CNT}, 33'd0);
    @(posedge clk); #1;

    // Saturation: preload the write counter just below the limit
    force dut.WR_ERR_CNT = 16'hFFFE;
    @(posedge clk); #1;
    release dut.WR_ERR_CNT;
    do_write(4'd10, 8'd0, 0);
    @(negedge clk); chk("sat_reach", WR_ERR_CNT, 16'hFFFF);
    @(posedge clk); #1;
    do_write(4'd11, 8'd1, 0);
    @(negedge clk); chk("sat_hold", WR_ERR_CNT, 16'hFFFF);
    @(posedge clk); #1;
    if (b_q.size() != 0 || r_q.size() != 0) fail("scoreboard_not_empty");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
